// File: rtl/game_pkg.sv
// Shared definitions for the Morse-game blocks: round-controller state
// encoding and the default timing/round constants.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int TICK_DIV_DEF   = 50000000;
  localparam int MAX_ROUNDS_DEF = 10;
  localparam int RND_W_DEF      = 4;

endpackage

// File: rtl/timer_round_ctrl_if.sv
// Signal bundle between the game environment and timer_round_ctrl; the
// controller sits on the slave modport, the environment on master.
interface timer_round_ctrl_if #(
  parameter int RND_W = game_pkg::RND_W_DEF
);
  import game_pkg::*;

  // answer_valid is a one-cycle strobe with no back-pressure: answer_correct
  // is meaningful only in that cycle, and a strobe outside RUN is dropped.
  logic             start;
  logic             abort;
  logic             answer_valid;
  logic             answer_correct;
  logic             timeout_in;
  logic             pause;
  logic             reconfig;
  logic             sec_tick;
  logic             round_active;
  logic             hit_pulse;
  logic             miss_pulse;
  logic [RND_W-1:0] round_cnt;
  logic [RND_W-1:0] score;
  logic             game_over;
  state_t           state_dbg;

  modport master (
    output start, abort, answer_valid, answer_correct, timeout_in, pause,
    input  reconfig, sec_tick, round_active, hit_pulse, miss_pulse,
           round_cnt, score, game_over, state_dbg
  );

  modport slave (
    input  start, abort, answer_valid, answer_correct, timeout_in, pause,
    output reconfig, sec_tick, round_active, hit_pulse, miss_pulse,
           round_cnt, score, game_over, state_dbg
  );

endinterface

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts 0..TICK_DIV-1 while en is high and raises a
// registered tick in the cycle the count sits at TICK_DIV-1.
module sec_prescaler #(
  parameter int TICK_DIV = game_pkg::TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE   = CNT_W'(TICK_DIV - 2);

  logic [CNT_W-1:0] cnt;

  // tick is set on the edge that moves cnt onto LAST, so it lines up with
  // that count value while staying a flop output; a held count drops it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == PRE);
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_round_ctrl.sv
// Round sequencer for one Morse-game session: reloads the digit timer,
// generates its seconds tick, scores each round and flags game over.
// Build option: TIMER_ROUND_CTRL_PAUSE_EN lets `pause` freeze the prescaler.
module timer_round_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int MAX_ROUNDS = MAX_ROUNDS_DEF,
  parameter int RND_W      = RND_W_DEF
) (
  input logic               clk,
  input logic               rst,
  timer_round_ctrl_if.slave bus
);

  state_t           state;
  state_t           stateNext;
  logic [RND_W-1:0] roundCnt;
  logic [RND_W-1:0] scoreCnt;
  logic             outcomeHit;
  logic             runStay;
  logic             tickEn;
  logic             tick;

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (bus.start) stateNext = LOAD;
      LOAD:    stateNext = RUN;
      RUN:     if (bus.answer_valid || bus.timeout_in) stateNext = RESULT;
      RESULT:  stateNext = (roundCnt == RND_W'(MAX_ROUNDS)) ? DONE : LOAD;
      DONE:    if (bus.start) stateNext = LOAD;
      default: stateNext = IDLE;
    endcase
    if (bus.abort) stateNext = IDLE;
  end

  // Counters update on entry to RESULT so the pulse and the new totals are
  // visible in the same cycle; abort never reaches RESULT, so it holds them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      roundCnt   <= '0;
      scoreCnt   <= '0;
      outcomeHit <= 1'b0;
    end else begin
      state <= stateNext;
      if (stateNext == LOAD && (state == IDLE || state == DONE)) begin
        roundCnt <= '0;
        scoreCnt <= '0;
      end else if (state == RUN && stateNext == RESULT) begin
        roundCnt   <= roundCnt + RND_W'(1);
        outcomeHit <= bus.answer_valid && bus.answer_correct;
        if (bus.answer_valid && bus.answer_correct && scoreCnt != {RND_W{1'b1}})
          scoreCnt <= scoreCnt + RND_W'(1);
      end
    end
  end

  // Only count while staying in RUN, so no tick can land in RESULT or LOAD.
  assign runStay = (state == RUN) && (stateNext == RUN);

`ifdef TIMER_ROUND_CTRL_PAUSE_EN
  assign tickEn = runStay && !bus.pause;
`else
  logic unusedPause;
  assign unusedPause = bus.pause;
  assign tickEn      = runStay;
`endif

  sec_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == LOAD),
    .en   (tickEn),
    .tick (tick)
  );

  assign bus.reconfig     = (state == LOAD);
  assign bus.sec_tick     = tick;
  assign bus.round_active = (state == RUN);
  assign bus.hit_pulse    = (state == RESULT) && outcomeHit;
  assign bus.miss_pulse   = (state == RESULT) && !outcomeHit;
  assign bus.round_cnt    = roundCnt;
  assign bus.score        = scoreCnt;
  assign bus.game_over    = (state == DONE);
  assign bus.state_dbg    = state;

endmodule
